// File: rtl/aes_decrypt_engine_pkg.sv
// AES-128 shared definitions: block and key types, round count, FSM encoding and byte tables.
package AESDefinitions;

  typedef logic [127:0] state_t;
  typedef logic [127:0] key_t;
  typedef logic [127:0] roundKey_t;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} aes_fsm_e;

  // Tables are flattened with entry 0 in the leftmost byte so a byte value indexes directly.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  // Entry i is the constant for round key i; entry 0 and 11..15 are unused.
  localparam logic [0:127] RCON = 128'h0001020408102040801b360000000000;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    return RCON[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/aes_decrypt_engine_round.sv
// One AES-128 inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module InverseRoundStep
  import AESDefinitions::*;
(
  input  state_t    state_i,
  input  roundKey_t round_key_i,
  input  logic      last_round_i,
  output state_t    state_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  state_t shifted, subbed, keyed, mixed;

  // Byte r+4c (row r, column c) sits at the MSB end; row r rotates right by r columns.
  always_comb begin
    shifted = '0;
    subbed  = '0;
    mixed   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[8*(15-(r+4*c)) +: 8] = state_i[8*(15-(r+4*((c+4-r)%4))) +: 8];
      end
    end
    for (int i = 0; i < 16; i++) subbed[8*i +: 8] = inv_sbox(shifted[8*i +: 8]);
    keyed = subbed ^ round_key_i;
    for (int c = 0; c < 4; c++) mixed[32*c +: 32] = inv_mix_col(keyed[32*c +: 32]);
    state_o = last_round_i ? keyed : mixed;
  end

endmodule

// File: rtl/aes_decrypt_engine.sv
// Iterative AES-128 decryptor with a one-entry expanded-key cache.
// state  | meaning
// IDLE   | waiting for a block; in_ready high
// EXPAND | building rk1..rk10, one per cycle (cnt 1..10)
// ROUND  | one inverse round per cycle (cnt 10..0)
// DONE   | plaintext on out until out_ready
module aes_decrypt_engine
  import AESDefinitions::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t in,
  input  key_t   key,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t out
);

  aes_fsm_e   state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       cache_valid_q, cache_valid_d;
  logic       in_ready_q, in_ready_d;
  state_t     blk_q, blk_d;
  roundKey_t  rk_q [0:NUM_ROUNDS];

  logic       accept, key_hit;
  logic [3:0] prev_idx;
  roundKey_t  rk_cur, rk_next;
  state_t     step_out;

  function automatic roundKey_t expand_step(input roundKey_t prev, input logic [3:0] idx);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = prev;
    t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon(idx), 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // rk_q[0] doubles as the cached key.
  assign accept   = in_valid & in_ready_q;
  assign key_hit  = cache_valid_q && (rk_q[0] == key);
  assign prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
  assign rk_cur   = rk_q[cnt_q];
  assign rk_next  = expand_step(rk_q[prev_idx], cnt_q);

  InverseRoundStep u_step (
    .state_i      (blk_q),
    .round_key_i  (rk_cur),
    .last_round_i (cnt_q == 4'd0),
    .state_o      (step_out)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cache_valid_d = cache_valid_q;
    blk_d         = blk_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          blk_d = in;
          if (key_hit) begin
            state_d = ROUND;
            cnt_d   = 4'(NUM_ROUNDS);
          end else begin
            state_d       = EXPAND;
            cnt_d         = 4'd1;
            cache_valid_d = 1'b0;
          end
        end
      end
      EXPAND: begin
        if (cnt_q == 4'(NUM_ROUNDS)) begin
          state_d       = ROUND;
          cache_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ROUND: begin
        blk_d = (cnt_q == 4'(NUM_ROUNDS)) ? (blk_q ^ rk_cur) : step_out;
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cache_valid_q <= 1'b0;
      in_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cache_valid_q <= cache_valid_d;
      in_ready_q    <= in_ready_d;
    end
  end

  always_ff @(posedge clock) begin
    blk_q <= blk_d;
    if (reset) begin
      if (state_q == IDLE && accept && !key_hit) rk_q[0] <= key;
      if (state_q == EXPAND) rk_q[cnt_q] <= rk_next;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == DONE);
  assign out       = out_valid ? blk_q : '0;

endmodule

// File: tb/tb_aes_decrypt_engine.sv
// Directed bench for aes_decrypt_engine: FIPS-197 vectors, key-cache latency, backpressure, reset.
module tb_aes_decrypt_engine;

  logic         clock = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_blk, key_in, out_blk;
  int           checks = 0;
  int           errors = 0;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  always #5 clock = ~clock;

  aes_decrypt_engine dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_blk),
    .key       (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_blk)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Submit one block, scramble in/key right after the accept edge, measure cycles to out_valid.
  task automatic run_block(input string tag, input logic [127:0] c, input logic [127:0] k,
                           input int exp_lat, input bit check_pt, input logic [127:0] exp_pt);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk({tag, " ready"}, 128'(in_ready), 128'd1);
    in_blk   = c;
    key_in   = k;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_blk   = rnd128();
    key_in   = rnd128();
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, 128'(lat), 128'(exp_lat));
    if (check_pt) chk({tag, " out"}, out_blk, exp_pt);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " drain valid"}, 128'(out_valid), 128'd0);
    chk({tag, " drain out"}, out_blk, 128'd0);
    chk({tag, " drain ready"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    int lat;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_blk    = '0;
    key_in    = '0;
    tick();
    tick();
    chk("rst in_ready", 128'(in_ready), 128'd0);
    chk("rst out_valid", 128'(out_valid), 128'd0);
    chk("rst out", out_blk, 128'd0);
    reset = 1'b1;
    chk("pre-edge in_ready", 128'(in_ready), 128'd0);
    tick();
    chk("post-rst in_ready", 128'(in_ready), 128'd1);

    run_block("v1 miss", C1, K1, 21, 1'b1, P1);
    chk("v1 done in_ready", 128'(in_ready), 128'd0);

    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      in_blk   = rnd128();
      key_in   = rnd128();
      tick();
      chk("hold out", out_blk, P1);
      chk("hold valid", 128'(out_valid), 128'd1);
      chk("hold in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    drain("v1");

    run_block("v1 hit", C1, K1, 11, 1'b1, P1);
    drain("v1 hit");
    run_block("k1 c2 hit", C2, K1, 11, 1'b0, '0);
    drain("k1 c2");
    run_block("v2 miss", C2, K2, 21, 1'b1, P2);
    drain("v2");
    run_block("v1 remiss", C1, K1, 21, 1'b1, P1);
    drain("v1 remiss");

    in_blk   = C1;
    key_in   = K1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst-test accepted", 128'(in_ready), 128'd0);
    repeat (5) tick();
    chk("rst-test mid valid", 128'(out_valid), 128'd0);
    reset = 1'b0;
    tick();
    chk("rst-test valid", 128'(out_valid), 128'd0);
    chk("rst-test in_ready", 128'(in_ready), 128'd0);
    tick();
    reset = 1'b1;
    run_block("v1 after rst", C1, K1, 21, 1'b1, P1);

    out_ready = 1'b1;
    in_blk    = C1;
    key_in    = K1;
    in_valid  = 1'b1;
    for (int n = 0; n < 2; n++) begin
      tick();
      chk("b2b gap valid", 128'(out_valid), 128'd0);
      chk("b2b gap in_ready", 128'(in_ready), 128'd1);
      tick();
      chk("b2b accepted", 128'(in_ready), 128'd0);
      lat = 0;
      while (!out_valid && lat < 60) begin
        tick();
        lat++;
      end
      chk("b2b latency", 128'(lat), 128'd11);
      chk("b2b out", out_blk, P1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_engine.md
AES_DECRYPT_ENGINE -- requirements
Module: aes_decrypt_engine

Interface
REQ-001 SHALL expose clock  input  1  sole clock; all state updates on the rising edge.
REQ-002 SHALL expose reset  input  1  synchronous, active-low reset; sampled on the clock edge.
REQ-003 SHALL expose in_valid  input  1  ciphertext and key are valid.
REQ-004 SHALL expose in_ready  output  1  engine can accept a block.
REQ-005 SHALL expose in  input  128 (state_t)  ciphertext block.
REQ-006 SHALL expose key  input  128 (key_t)  AES-128 cipher key.
REQ-007 SHALL expose out_valid  output  1  plaintext available.
REQ-008 SHALL expose out_ready  input  1  consumer accepts plaintext.
REQ-009 SHALL expose out  output  128 (state_t)  plaintext block.

Function
REQ-010 SHALL perform iterative AES-128 inverse cipher (FIPS-197), one round per clock, bit-exact with the team's forward encoder.
REQ-011 SHALL implement FSM states IDLE, EXPAND, ROUND, DONE.
REQ-012 SHALL drive in_ready = 1 only in IDLE; accept occurs on an edge where in_valid & in_ready, latching in and key.
REQ-013 On accept, SHALL go to EXPAND unless the cached key is valid and equal to key, in which case SHALL go directly to ROUND.
REQ-014 EXPAND SHALL last exactly 10 cycles, computing one round key per cycle (rk1..rk10) into an 11-entry register array (rk0 = key), then set cache-valid, store the key and enter ROUND.
REQ-015 ROUND SHALL last exactly 11 cycles: cycle 0 AddRoundKey(rk10); cycles 1-9 InvShiftRows, InvSubBytes, AddRoundKey(rk9..rk1), InvMixColumns; cycle 10 the same without InvMixColumns using rk0.
REQ-016 A 4-bit round counter SHALL count down 10..0 in ROUND and 1..10 in EXPAND; it SHALL NOT wrap. The transition out of each state SHALL occur at the terminal count.
REQ-017 Latency from the accept edge to out_valid high SHALL be 21 cycles on a key miss and 11 cycles on a key hit.
REQ-018 In DONE, out_valid SHALL be 1 and out SHALL hold the plaintext stable until out_ready.
REQ-019 On an edge where out_valid & out_ready, the FSM SHALL return to IDLE; in_ready SHALL rise the following cycle (no same-cycle turnaround).
REQ-020 in_valid while in_ready = 0 SHALL be ignored; in and key changes outside the accept edge SHALL NOT affect the block in flight.
REQ-021 out SHALL be 0 whenever out_valid = 0.

Reset
REQ-022 While reset = 0 at an edge: FSM to IDLE, counter to 0, cache-valid to 0, in_ready to 0, out_valid to 0, out to 0.
REQ-023 in_ready SHALL become 1 on the first edge after reset deasserts.
REQ-024 Reset mid-EXPAND, mid-ROUND or in DONE SHALL abandon the block with no output and SHALL invalidate the key cache.

Structure
REQ-025 The AESDefinitions package SHALL hold state_t, key_t, roundKey_t, NUM_ROUNDS (10), the S-box, the inverse S-box and the Rcon tables; this block SHALL import it.
REQ-026 The datapath round SHALL be one sub-module, InverseRoundStep (state, roundKey, lastRound flag -> state), purely combinational; key expansion and the FSM stay in the top module.

Verification
REQ-027 Key 000102030405060708090a0b0c0d0e0f with in 69c4e0d86a7b0430d8cdb78070b4c55a SHALL produce out 00112233445566778899aabbccddeeff, with out_valid 21 cycles after accept.
REQ-028 The same key again with in 3925841d02dc09fbdc118597196a0b32 SHALL hit the cache, with out_valid 11 cycles after accept.
REQ-029 Key 2b7e151628aed2a6abf7158809cf4f3c with in 3925841d02dc09fbdc118597196a0b32 SHALL miss the cache and produce 3243f6a8885a308d313198a2e0370734 at 21 cycles.
REQ-030 Holding out_ready = 0 for 5 cycles in DONE SHALL keep out stable and in_ready = 0; in_valid pulses during that time SHALL be ignored.
REQ-031 Reset asserted at ROUND cycle 5 and then a resubmission of the REQ-027 vector SHALL take 21 cycles (cache invalidated) and produce the correct plaintext.
REQ-032 Back-to-back blocks with out_ready tied to 1 and in_valid tied to 1 SHALL show one idle cycle between out_valid and the next accept.
